// File: rtl/spike_weight_streamer.sv
// Presynaptic fan-in stage: latches one spike vector per timestep and streams the weights of its
// active inputs as a burst of at least two beats. Define ZERO_WEIGHT_SKIP_EN to drop zero-weight inputs.
module spike_weight_streamer #(
  parameter int N_IN    = 16,
  parameter int DW      = 8,
  parameter int GAP_CYC = 20,
  localparam int AW     = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN-1:0]      spk_vec,
  input  logic                 spk_valid,
  output logic                 spk_ready,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  output logic signed [DW-1:0] weight_out,
  output logic                 weight_valid_out,
  output logic                 weight_last_out,
  output logic                 busy,
  output logic                 ts_done
);

  localparam int CW = $clog2(N_IN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PAD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic signed [DW-1:0]  mem_q [N_IN];
  logic signed [DW-1:0]  mem_d [N_IN];
  logic signed [DW-1:0]  weight_q, weight_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [N_IN-1:0]       eff_vec;
  logic [N_IN-1:0]       eff_in;
  logic [N_IN-1:0]       above_mask;
  logic                  rem;
  logic                  cur_active;

`ifdef ZERO_WEIGHT_SKIP_EN
  logic [N_IN-1:0] nz_mask;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      nz_mask[i] = (mem_q[i] != '0);
    end
  end

  assign eff_vec = vec_q & nz_mask;
  assign eff_in  = spk_vec & nz_mask;
`else
  assign eff_vec = vec_q;
  assign eff_in  = spk_vec;
`endif

  // rem looks only at inputs strictly above the one being scanned
  assign above_mask = {N_IN{1'b1}} << idx_q << 1;
  assign rem        = |(eff_vec & above_mask);
  assign cur_active = eff_vec[idx_q];

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    weight_d = '0;
    valid_d  = 1'b0;
    last_d   = 1'b0;

    mem_d = mem_q;
    if (wr_en && (32'(wr_addr) < N_IN)) begin
      mem_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (spk_valid && ready_q) begin
          vec_d   = spk_vec;
          idx_d   = '0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (eff_in == '0) ? S_PAD : S_SCAN;
        end
      end

      S_SCAN: begin
        if (cur_active) begin
          weight_d = mem_q[idx_q];
          valid_d  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (!rem) begin
            if (cnt_q != '0) begin
              last_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              state_d = S_PAD;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (!rem) begin
          state_d = S_PAD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      // Pad with zero-weight beats so every burst is at least two beats long
      S_PAD: begin
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          last_d  = 1'b1;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      weight_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      weight_q <= weight_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      mem_q    <= mem_d;
    end
  end

  assign spk_ready        = ready_q;
  assign weight_out       = weight_q;
  assign weight_valid_out = valid_q;
  assign weight_last_out  = last_q;
  assign ts_done          = last_q;
  assign busy             = busy_q;

endmodule
